// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage MIPS datapath.
// Latches the decoded control bundles, operands, immediate, PC and register
// addresses at the ID->EX boundary. Adds a valid bit, hold (stall) and
// bubble insertion (flush), and saturating bubble/stall counters.
// Every output comes straight from a flop; there is no input->output path.
module id_ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int RA_W    = 5,
    parameter int WB_W    = 2,
    parameter int M_W     = 2,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic [WB_W-1:0]      WB_i,
    input  logic [M_W-1:0]       M_i,
    input  logic [ALUOP_W+1:0]   EX_i,
    input  logic [DATA_W-1:0]    PC_i,
    input  logic [DATA_W-1:0]    RSdata_i,
    input  logic [DATA_W-1:0]    RTdata_i,
    input  logic [DATA_W-1:0]    imm_i,
    input  logic [RA_W-1:0]      RSaddr_i,
    input  logic [RA_W-1:0]      RTaddr_i,
    input  logic [RA_W-1:0]      RDaddr_i,
    output logic                 valid_o,
    output logic [WB_W-1:0]      WB_o,
    output logic [M_W-1:0]       M_o,
    output logic                 RegDst_o,
    output logic [ALUOP_W-1:0]   ALUOp_o,
    output logic                 ALUSrc_o,
    output logic [DATA_W-1:0]    PC_o,
    output logic [DATA_W-1:0]    RSdata_o,
    output logic [DATA_W-1:0]    RTdata_o,
    output logic [DATA_W-1:0]    imm_o,
    output logic [RA_W-1:0]      RSaddr_o,
    output logic [RA_W-1:0]      RTaddr_o,
    output logic [RA_W-1:0]      RDaddr_o,
    output logic [CNT_W-1:0]     bubble_cnt_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    localparam int EX_W = ALUOP_W + 2;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == {CNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + CNT_W'(1);
        end
        return res;
    endfunction

    logic                valid_q,   valid_d;
    logic [WB_W-1:0]     wb_q,      wb_d;
    logic [M_W-1:0]      m_q,       m_d;
    logic [EX_W-1:0]     ex_q,      ex_d;
    logic [DATA_W-1:0]   pc_q,      pc_d;
    logic [DATA_W-1:0]   rs_data_q, rs_data_d;
    logic [DATA_W-1:0]   rt_data_q, rt_data_d;
    logic [DATA_W-1:0]   imm_q,     imm_d;
    logic [RA_W-1:0]     rs_addr_q, rs_addr_d;
    logic [RA_W-1:0]     rt_addr_q, rt_addr_d;
    logic [RA_W-1:0]     rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q,  stall_cnt_d;

    // Next-state selection: flush beats stall, stall beats a normal load.
    always_comb begin
        valid_d      = valid_q;
        wb_d         = wb_q;
        m_d          = m_q;
        ex_d         = ex_q;
        pc_d         = pc_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        rs_addr_d    = rs_addr_q;
        rt_addr_d    = rt_addr_q;
        rd_addr_d    = rd_addr_q;
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;

        if (flush_i) begin
            // Bubble: addresses are cleared too so forwarding never matches it.
            valid_d      = 1'b0;
            wb_d         = '0;
            m_d          = '0;
            ex_d         = '0;
            pc_d         = '0;
            rs_data_d    = '0;
            rt_data_d    = '0;
            imm_d        = '0;
            rs_addr_d    = '0;
            rt_addr_d    = '0;
            rd_addr_d    = '0;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else if (stall_i) begin
            stall_cnt_d  = sat_inc(stall_cnt_q);
        end else begin
            // An invalid slot carries its data but can never write anything.
            valid_d      = valid_i;
            wb_d         = valid_i ? WB_i : '0;
            m_d          = valid_i ? M_i  : '0;
            ex_d         = valid_i ? EX_i : '0;
            pc_d         = PC_i;
            rs_data_d    = RSdata_i;
            rt_data_d    = RTdata_i;
            imm_d        = imm_i;
            rs_addr_d    = RSaddr_i;
            rt_addr_d    = RTaddr_i;
            rd_addr_d    = RDaddr_i;
        end
    end

    // Stage state register with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q      <= 1'b0;
            wb_q         <= '0;
            m_q          <= '0;
            ex_q         <= '0;
            pc_q         <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rd_addr_q    <= '0;
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            wb_q         <= wb_d;
            m_q          <= m_d;
            ex_q         <= ex_d;
            pc_q         <= pc_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_addr_q    <= rs_addr_d;
            rt_addr_q    <= rt_addr_d;
            rd_addr_q    <= rd_addr_d;
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign valid_o      = valid_q;
    assign WB_o         = wb_q;
    assign M_o          = m_q;
    assign RegDst_o     = ex_q[EX_W-1];
    assign ALUOp_o      = ex_q[EX_W-2:1];
    assign ALUSrc_o     = ex_q[0];
    assign PC_o         = pc_q;
    assign RSdata_o     = rs_data_q;
    assign RTdata_o     = rt_data_q;
    assign imm_o        = imm_q;
    assign RSaddr_o     = rs_addr_q;
    assign RTaddr_o     = rt_addr_q;
    assign RDaddr_o     = rd_addr_q;
    assign bubble_cnt_o = bubble_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed vector table, hand-written
// reset/saturation sequences, then random stimulus against a reference model.
// A second instance with 2-bit counters exercises counter saturation.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        valid;
        logic [1:0]  wb;
        logic [1:0]  m;
        logic [3:0]  ex;
        logic [31:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rsa;
        logic [4:0]  rta;
        logic [4:0]  rda;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  wb;
        logic [1:0]  m;
        logic [3:0]  ex;
        logic [31:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rsa;
        logic [4:0]  rta;
        logic [4:0]  rda;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
        int   bub;
        int   stl;
    } vec_t;

    logic        clk, rst_n;
    logic        stall, flush, valid;
    logic [1:0]  wb, m;
    logic [3:0]  ex;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rsa, rta, rda;

    logic        valid_o, regdst_o, alusrc_o;
    logic [1:0]  wb_o, m_o, aluop_o;
    logic [31:0] pc_o, rsd_o, rtd_o, imm_o;
    logic [4:0]  rsa_o, rta_o, rda_o;
    logic [15:0] bub_o, stl_o;

    logic        s_valid_o, s_regdst_o, s_alusrc_o;
    logic [1:0]  s_wb_o, s_m_o, s_aluop_o;
    logic [31:0] s_pc_o, s_rsd_o, s_rtd_o, s_imm_o;
    logic [4:0]  s_rsa_o, s_rta_o, s_rda_o;
    logic [1:0]  s_bub_o, s_stl_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    id_ex_pipe_reg dut (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .valid_i(valid),
        .WB_i(wb), .M_i(m), .EX_i(ex), .PC_i(pc), .RSdata_i(rsd), .RTdata_i(rtd),
        .imm_i(imm), .RSaddr_i(rsa), .RTaddr_i(rta), .RDaddr_i(rda),
        .valid_o(valid_o), .WB_o(wb_o), .M_o(m_o), .RegDst_o(regdst_o),
        .ALUOp_o(aluop_o), .ALUSrc_o(alusrc_o), .PC_o(pc_o), .RSdata_o(rsd_o),
        .RTdata_o(rtd_o), .imm_o(imm_o), .RSaddr_o(rsa_o), .RTaddr_o(rta_o),
        .RDaddr_o(rda_o), .bubble_cnt_o(bub_o), .stall_cnt_o(stl_o)
    );

    id_ex_pipe_reg #(.CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush), .valid_i(valid),
        .WB_i(wb), .M_i(m), .EX_i(ex), .PC_i(pc), .RSdata_i(rsd), .RTdata_i(rtd),
        .imm_i(imm), .RSaddr_i(rsa), .RTaddr_i(rta), .RDaddr_i(rda),
        .valid_o(s_valid_o), .WB_o(s_wb_o), .M_o(s_m_o), .RegDst_o(s_regdst_o),
        .ALUOp_o(s_aluop_o), .ALUSrc_o(s_alusrc_o), .PC_o(s_pc_o), .RSdata_o(s_rsd_o),
        .RTdata_o(s_rtd_o), .imm_o(s_imm_o), .RSaddr_o(s_rsa_o), .RTaddr_o(s_rta_o),
        .RDaddr_o(s_rda_o), .bubble_cnt_o(s_bub_o), .stall_cnt_o(s_stl_o)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Compare every output of the main instance, plus both instances' counters.
    task automatic compare_all(input string tag, input out_t e, input int bub, input int stl);
        chk({tag, ".valid"},  64'(valid_o), 64'(e.valid));
        chk({tag, ".WB"},     64'(wb_o),    64'(e.wb));
        chk({tag, ".M"},      64'(m_o),     64'(e.m));
        chk({tag, ".RegDst"}, 64'(regdst_o), 64'(e.ex[3]));
        chk({tag, ".ALUOp"},  64'(aluop_o),  64'(e.ex[2:1]));
        chk({tag, ".ALUSrc"}, 64'(alusrc_o), 64'(e.ex[0]));
        chk({tag, ".PC"},     64'(pc_o),  64'(e.pc));
        chk({tag, ".RSdata"}, 64'(rsd_o), 64'(e.rsd));
        chk({tag, ".RTdata"}, 64'(rtd_o), 64'(e.rtd));
        chk({tag, ".imm"},    64'(imm_o), 64'(e.imm));
        chk({tag, ".RSaddr"}, 64'(rsa_o), 64'(e.rsa));
        chk({tag, ".RTaddr"}, 64'(rta_o), 64'(e.rta));
        chk({tag, ".RDaddr"}, 64'(rda_o), 64'(e.rda));
        chk({tag, ".bubble_cnt"}, 64'(bub_o), 64'(imin(bub, 65535)));
        chk({tag, ".stall_cnt"},  64'(stl_o), 64'(imin(stl, 65535)));
        chk({tag, ".sat_bubble_cnt"}, 64'(s_bub_o), 64'(imin(bub, 3)));
        chk({tag, ".sat_stall_cnt"},  64'(s_stl_o), 64'(imin(stl, 3)));
    endtask

    task automatic apply_in(input in_t v);
        stall = v.stall; flush = v.flush; valid = v.valid;
        wb = v.wb; m = v.m; ex = v.ex; pc = v.pc;
        rsd = v.rsd; rtd = v.rtd; imm = v.imm;
        rsa = v.rsa; rta = v.rta; rda = v.rda;
    endtask

    function automatic in_t mk_in(input logic s, input logic f, input logic v,
                                  input logic [1:0] w, input logic [1:0] mm, input logic [3:0] e,
                                  input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] i, input logic [4:0] r1, input logic [4:0] r2,
                                  input logic [4:0] r3);
        in_t x;
        x.stall = s; x.flush = f; x.valid = v; x.wb = w; x.m = mm; x.ex = e;
        x.pc = p; x.rsd = a; x.rtd = b; x.imm = i; x.rsa = r1; x.rta = r2; x.rda = r3;
        return x;
    endfunction

    function automatic out_t mk_out(input logic v, input logic [1:0] w, input logic [1:0] mm,
                                    input logic [3:0] e, input logic [31:0] p, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] i, input logic [4:0] r1,
                                    input logic [4:0] r2, input logic [4:0] r3);
        out_t x;
        x.valid = v; x.wb = w; x.m = mm; x.ex = e; x.pc = p; x.rsd = a; x.rtd = b;
        x.imm = i; x.rsa = r1; x.rta = r2; x.rda = r3;
        return x;
    endfunction

    task automatic idle_inputs();
        apply_in(mk_in(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                       5'd0, 5'd0, 5'd0));
    endtask

    // Hold reset over two edges, release just after an edge.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[7];
    out_t zero_o;

    initial begin
        zero_o = '0;
        rst_n  = 1'b1;
        idle_inputs();
        #2;
        do_reset();
        compare_all("reset", zero_o, 0, 0);

        // ---------------- directed vector table ----------------
        vecs[0].in  = mk_in(1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 4'b1101, 32'h44, 32'hDEADBEEF,
                            32'h12345678, 32'hFFFFFFF0, 5'd3, 5'd9, 5'd17);
        vecs[0].exp = mk_out(1'b1, 2'b10, 2'b01, 4'b1101, 32'h44, 32'hDEADBEEF,
                             32'h12345678, 32'hFFFFFFF0, 5'd3, 5'd9, 5'd17);
        vecs[0].bub = 0; vecs[0].stl = 0;
        for (int i = 1; i <= 3; i++) begin
            vecs[i].in  = mk_in(1'b1, 1'b0, 1'b1, 2'b11, 2'b10, 4'b0011, 32'h48 + 32'(i),
                                32'h1111 * 32'(i), 32'h2222 * 32'(i), 32'(i), 5'(20 + i),
                                5'(24 + i), 5'(28 + i));
            vecs[i].exp = vecs[0].exp;
            vecs[i].bub = 0; vecs[i].stl = i;
        end
        vecs[4].in  = mk_in(1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 4'b0010, 32'h50, 32'hCAFEF00D,
                            32'h0BADBEEF, 32'h7, 5'd1, 5'd2, 5'd4);
        vecs[4].exp = mk_out(1'b1, 2'b01, 2'b10, 4'b0010, 32'h50, 32'hCAFEF00D,
                             32'h0BADBEEF, 32'h7, 5'd1, 5'd2, 5'd4);
        vecs[4].bub = 0; vecs[4].stl = 3;
        vecs[5].in  = mk_in(1'b1, 1'b1, 1'b1, 2'b11, 2'b11, 4'b1111, 32'h54, 32'h99,
                            32'h98, 32'h97, 5'd7, 5'd8, 5'd6);
        vecs[5].exp = zero_o;
        vecs[5].bub = 1; vecs[5].stl = 3;
        vecs[6].in  = mk_in(1'b0, 1'b0, 1'b0, 2'b11, 2'b10, 4'b1111, 32'h100, 32'hAAAA5555,
                            32'h5555AAAA, 32'h80, 5'd10, 5'd11, 5'd12);
        vecs[6].exp = mk_out(1'b0, 2'b00, 2'b00, 4'b0000, 32'h100, 32'hAAAA5555,
                             32'h5555AAAA, 32'h80, 5'd10, 5'd11, 5'd12);
        vecs[6].bub = 1; vecs[6].stl = 3;

        for (int i = 0; i < 7; i++) begin
            apply_in(vecs[i].in);
            step();
            compare_all($sformatf("vec%0d", i), vecs[i].exp, vecs[i].bub, vecs[i].stl);
        end

        // ---------------- asynchronous reset mid-operation ----------------
        apply_in(mk_in(1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 4'h0, 32'h40, 32'h5, 32'h6, 32'h7,
                       5'd1, 5'd1, 5'd1));
        step();
        chk("pre_reset.WB", 64'(wb_o), 64'(2'b11));
        chk("pre_reset.PC", 64'(pc_o), 64'h40);
        stall = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        compare_all("async_reset", zero_o, 0, 0);
        @(posedge clk);
        #1;
        compare_all("reset_held", zero_o, 0, 0);
        rst_n = 1'b1;
        idle_inputs();

        // ---------------- counter saturation ----------------
        for (int i = 1; i <= 5; i++) begin
            apply_in(mk_in(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 4'hF, 32'(i), 32'(i), 32'(i),
                           32'(i), 5'(i), 5'(i), 5'(i)));
            step();
            compare_all($sformatf("sat_flush%0d", i), zero_o, i, 0);
        end
        for (int i = 1; i <= 4; i++) begin
            apply_in(mk_in(1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 4'h1, 32'(i), 32'(i), 32'(i),
                           32'(i), 5'(i), 5'(i), 5'(i)));
            step();
            compare_all($sformatf("sat_stall%0d", i), zero_o, 5, i);
        end

        // ---------------- randomized run against reference model ----------------
        begin
            out_t mdl;
            in_t  r;
            int   bub, stl;
            idle_inputs();
            do_reset();
            mdl = '0; bub = 0; stl = 0;
            for (int n = 0; n < 400; n++) begin
                r.stall = ($urandom_range(0, 3) == 0);
                r.flush = ($urandom_range(0, 6) == 0);
                r.valid = ($urandom_range(0, 4) != 0);
                r.wb  = 2'($urandom);  r.m   = 2'($urandom);  r.ex  = 4'($urandom);
                r.pc  = $urandom;      r.rsd = $urandom;      r.rtd = $urandom;
                r.imm = $urandom;
                r.rsa = 5'($urandom);  r.rta = 5'($urandom);  r.rda = 5'($urandom);
                apply_in(r);
                step();
                if (r.flush) begin
                    mdl = '0;
                    bub = bub + 1;
                end else if (r.stall) begin
                    stl = stl + 1;
                end else begin
                    mdl.valid = r.valid;
                    mdl.wb  = r.valid ? r.wb : 2'b00;
                    mdl.m   = r.valid ? r.m  : 2'b00;
                    mdl.ex  = r.valid ? r.ex : 4'b0000;
                    mdl.pc  = r.pc;  mdl.rsd = r.rsd; mdl.rtd = r.rtd; mdl.imm = r.imm;
                    mdl.rsa = r.rsa; mdl.rta = r.rta; mdl.rda = r.rda;
                end
                compare_all($sformatf("rand%0d", n), mdl, bub, stl);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
